// File: rtl/pac_sprite_anim_if.sv
// Pixel query stream for pac_sprite_anim: pixel coordinate in, on-sprite verdict out.
interface pac_sprite_anim_if #(
    parameter int COORD_W = 11
);
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               pix_valid;
    logic               is_pac;
    logic               is_pac_valid;

    modport master (
        output pix_x, pix_y, pix_valid,
        input  is_pac, is_pac_valid
    );

    modport slave (
        input  pix_x, pix_y, pix_valid,
        output is_pac, is_pac_valid
    );
endinterface

// File: rtl/pac_sprite_anim.sv
// Pac-Man sprite pixel classifier: 2-stage hit pipeline plus per-frame mouth/facing animation.
// Optional death animation (ALIVE/DYING/GONE) is enabled with `define PAC_DEATH_ANIM_EN.
module pac_sprite_anim #(
    parameter int COORD_W         = 11,
    parameter int RADIUS          = 31,
    parameter int MOUTH_STEPS     = 4,
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               frame_tick,
    input  logic [COORD_W-1:0]                 pos_x,
    input  logic [COORD_W-1:0]                 pos_y,
    input  logic                               up,
    input  logic                               left,
    input  logic                               down,
    input  logic                               right,
    input  logic                               die,
    input  logic                               revive,
    pac_sprite_anim_if.slave                   pix,
    output logic [$clog2(MOUTH_STEPS+1)-1:0]   mouth_level
);

    localparam int STAGES = 2;
    localparam int SW     = COORD_W + 1;
    localparam int PW     = 2 * SW;
    localparam int ML_W   = $clog2(MOUTH_STEPS + 1);
    localparam int FC_W   = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [PW-1:0] R2   = PW'(RADIUS * RADIUS);
    localparam logic [PW-1:0] MS_P = PW'(MOUTH_STEPS);

    typedef enum logic [1:0] {
        FACE_RIGHT,
        FACE_LEFT,
        FACE_DOWN,
        FACE_UP
    } face_t;

    face_t                    r_face;
    logic [FC_W-1:0]          r_fc;
    logic [ML_W-1:0]          r_level;
    logic                     r_rising;
    logic [STAGES:1]          r_vld_pipe;
    logic signed [SW-1:0]     r_dx;
    logic signed [SW-1:0]     r_dy;
    logic                     r_is_pac;

    logic                     w_wrap;
    logic [ML_W-1:0]          w_level_nxt;
    logic                     w_rising_nxt;
    logic [SW-1:0]            w_adx;
    logic [SW-1:0]            w_ady;
    logic signed [SW-1:0]     w_a;
    logic [SW-1:0]            w_p;
    logic                     w_a_pos;
    logic [PW-1:0]            w_dist;
    logic [PW-1:0]            w_lhs;
    logic [PW-1:0]            w_rhs;
    logic                     w_mouth;
    logic [PW-1:0]            w_thr;
    logic                     w_visible;
    logic                     w_hit;

    // ---------------- facing ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_face <= FACE_RIGHT;
        end else if (frame_tick) begin
            if (up)         r_face <= FACE_UP;
            else if (left)  r_face <= FACE_LEFT;
            else if (down)  r_face <= FACE_DOWN;
            else if (right) r_face <= FACE_RIGHT;
        end
    end

    // ---------------- mouth ping-pong step ----------------
    always_comb begin
        w_wrap       = (r_fc == FC_W'(FRAMES_PER_STEP - 1));
        w_level_nxt  = r_level;
        w_rising_nxt = r_rising;
        if (r_rising) begin
            w_level_nxt = r_level + 1'b1;
            if (r_level == ML_W'(MOUTH_STEPS - 1)) w_rising_nxt = 1'b0;
        end else begin
            w_level_nxt = r_level - 1'b1;
            if (r_level == ML_W'(1)) w_rising_nxt = 1'b1;
        end
    end

`ifdef PAC_DEATH_ANIM_EN
    typedef enum logic [1:0] {
        ST_ALIVE,
        ST_DYING,
        ST_GONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_d;
    logic        w_die_ev;

    assign w_die_ev = die && !revive && (r_state == ST_ALIVE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_ALIVE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (revive) begin
            w_state_nxt = ST_ALIVE;
        end else begin
            case (r_state)
                ST_ALIVE: if (die) w_state_nxt = ST_DYING;
                ST_DYING: if (frame_tick && w_wrap && r_d == 3'd3) w_state_nxt = ST_GONE;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    // Frame counter restarts on die so shrink steps are a full period apart.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fc     <= '0;
            r_level  <= '0;
            r_rising <= 1'b1;
            r_d      <= '0;
        end else if (revive) begin
            r_fc     <= '0;
            r_level  <= '0;
            r_rising <= 1'b1;
        end else if (w_die_ev) begin
            r_fc <= '0;
            r_d  <= '0;
        end else if (frame_tick) begin
            r_fc <= w_wrap ? '0 : r_fc + 1'b1;
            if (w_wrap && r_state == ST_ALIVE) begin
                r_level  <= w_level_nxt;
                r_rising <= w_rising_nxt;
            end else if (w_wrap && r_state == ST_DYING) begin
                r_d <= r_d + 1'b1;
            end
        end
    end

    assign w_thr     = (r_state == ST_DYING) ? (R2 >> r_d) : R2;
    assign w_visible = (r_state != ST_GONE);
`else
    logic w_unused_death;
    assign w_unused_death = die ^ revive;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fc     <= '0;
            r_level  <= '0;
            r_rising <= 1'b1;
        end else if (frame_tick) begin
            r_fc <= w_wrap ? '0 : r_fc + 1'b1;
            if (w_wrap) begin
                r_level  <= w_level_nxt;
                r_rising <= w_rising_nxt;
            end
        end
    end

    assign w_thr     = R2;
    assign w_visible = 1'b1;
`endif

    // ---------------- stage 1: offsets from centre ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dx <= '0;
            r_dy <= '0;
        end else begin
            r_dx <= $signed({1'b0, pix.pix_x}) - $signed({1'b0, pos_x});
            r_dy <= $signed({1'b0, pix.pix_y}) - $signed({1'b0, pos_y});
        end
    end

    // ---------------- stage 2: body and mouth test ----------------
    // All animation state is sampled in the same cycle, so a pixel never sees a half-updated frame.
    always_comb begin
        w_adx = r_dx[SW-1] ? $unsigned(-r_dx) : $unsigned(r_dx);
        w_ady = r_dy[SW-1] ? $unsigned(-r_dy) : $unsigned(r_dy);
        w_dist = PW'(w_adx) * PW'(w_adx) + PW'(w_ady) * PW'(w_ady);
        case (r_face)
            FACE_RIGHT: begin w_a = r_dx;  w_p = w_ady; end
            FACE_LEFT:  begin w_a = -r_dx; w_p = w_ady; end
            FACE_DOWN:  begin w_a = r_dy;  w_p = w_adx; end
            default:    begin w_a = -r_dy; w_p = w_adx; end
        endcase
        w_a_pos = !w_a[SW-1] && (w_a != '0);
        w_lhs   = PW'(w_p) * MS_P;
        w_rhs   = PW'($unsigned(w_a)) * PW'(r_level);
        w_mouth = w_a_pos && (w_lhs < w_rhs);
        w_hit   = w_visible && (w_dist < w_thr) && !w_mouth;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vld_pipe <= '0;
            r_is_pac   <= 1'b0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], pix.pix_valid};
            r_is_pac   <= r_vld_pipe[1] && w_hit;
        end
    end

    assign pix.is_pac       = r_is_pac;
    assign pix.is_pac_valid = r_vld_pipe[STAGES];
    assign mouth_level      = r_level;

endmodule

// File: tb/tb_pac_sprite_anim.sv
// Randomized self-checking bench for pac_sprite_anim against a rule-level reference model.
module tb_pac_sprite_anim;
    localparam int CW  = 11;
    localparam int R   = 31;
    localparam int MS  = 4;
    localparam int FPS = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic frame_tick = 1'b0;
    logic [CW-1:0] pos_x = 11'd500;
    logic [CW-1:0] pos_y = 11'd400;
    logic up = 0, left = 0, down = 0, right = 0, die = 0, revive = 0;
    logic [$clog2(MS+1)-1:0] mouth_level;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_ticks = 0;
    int m_face  = 0; // 0 right, 1 left, 2 down, 3 up

    pac_sprite_anim_if #(.COORD_W(CW)) pif ();

    pac_sprite_anim #(
        .COORD_W(CW), .RADIUS(R), .MOUTH_STEPS(MS), .FRAMES_PER_STEP(FPS)
    ) dut (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
        .pos_x(pos_x), .pos_y(pos_y),
        .up(up), .left(left), .down(down), .right(right),
        .die(die), .revive(revive),
        .pix(pif.slave),
        .mouth_level(mouth_level)
    );

    always #5 clk = ~clk;

    // Triangle wave over completed mouth steps.
    function automatic int model_level();
        int s;
        s = (m_ticks / FPS) % (2 * MS);
        return (s <= MS) ? s : 2 * MS - s;
    endfunction

    function automatic bit model_pac(int px, int py, int cx, int cy);
        int dx, dy, a, p, lvl;
        bit body, mouth;
        dx = px - cx;
        dy = py - cy;
        lvl = model_level();
        body = (dx * dx + dy * dy) < R * R;
        case (m_face)
            0: begin a = dx;  p = (dy < 0) ? -dy : dy; end
            1: begin a = -dx; p = (dy < 0) ? -dy : dy; end
            2: begin a = dy;  p = (dx < 0) ? -dx : dx; end
            default: begin a = -dy; p = (dx < 0) ? -dx : dx; end
        endcase
        mouth = (a > 0) && (p * MS < a * lvl);
        return body && !mouth;
    endfunction

    task automatic do_reset();
        pif.pix_valid = 0;
        resetn = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        m_ticks = 0;
        m_face  = 0;
    endtask

    task automatic tick(input bit u, input bit l, input bit d, input bit r);
        up = u; left = l; down = d; right = r;
        frame_tick = 1;
        @(posedge clk);
        #1 frame_tick = 0;
        up = 0; left = 0; down = 0; right = 0;
        m_ticks++;
        if (u) m_face = 3;
        else if (l) m_face = 1;
        else if (d) m_face = 2;
        else if (r) m_face = 0;
    endtask

    // Drives one pixel; returns valid one cycle later and valid/is_pac two cycles later.
    task automatic send_pixel(input int px, input int py,
                              output bit v1, output bit v2, output bit p2);
        pif.pix_x = CW'(px);
        pif.pix_y = CW'(py);
        pif.pix_valid = 1;
        @(posedge clk);
        #1 pif.pix_valid = 0;
        v1 = pif.is_pac_valid;
        @(posedge clk);
        #1;
        v2 = pif.is_pac_valid;
        p2 = pif.is_pac;
    endtask

    task automatic test_reset();
        pif.pix_valid = 1;
        pif.pix_x = pos_x;
        pif.pix_y = pos_y;
        resetn = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({pif.is_pac, pif.is_pac_valid} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_outputs: got is_pac=%b valid=%b, want 0 0", pif.is_pac, pif.is_pac_valid);
        end
        n_checks++;
        if (mouth_level !== 0) begin
            n_errors++;
            $display("FAIL reset_mouth: got %0d, want 0", mouth_level);
        end
        pif.pix_valid = 0;
        resetn = 1;
        m_ticks = 0;
        m_face  = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_body();
        int offx[5] = '{10, 10, -10, 31, 0};
        int offy[5] = '{0, 0, 0, 0, 30};
        bit expp[5] = '{1, 0, 1, 0, 1};
        bit v1, v2, p2;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) for (int t = 0; t < 4 * FPS; t++) tick(0, 0, 0, 0);
            send_pixel(int'(pos_x) + offx[i], int'(pos_y) + offy[i], v1, v2, p2);
            n_checks++;
            if ({v1, v2, p2} !== {1'b0, 1'b1, expp[i]}) begin
                n_errors++;
                $display("FAIL body_%0d: got v1=%b v2=%b is_pac=%b, want 0 1 %b (lvl=%0d)",
                         i, v1, v2, p2, expp[i], mouth_level);
            end
        end
    endtask

    task automatic test_mouth_seq();
        int want;
        do_reset();
        for (int t = 1; t <= 36; t++) begin
            tick(0, 0, 0, 0);
            want = model_level();
            n_checks++;
            if (int'(mouth_level) !== want) begin
                n_errors++;
                $display("FAIL mouth_seq_t%0d: got %0d, want %0d", t, mouth_level, want);
            end
        end
    endtask

    task automatic test_facing();
        bit v1, v2, p2;
        do_reset();
        for (int t = 0; t < 4 * FPS - 1; t++) tick(0, 0, 0, 0);
        tick(1, 0, 0, 1);
        send_pixel(int'(pos_x), int'(pos_y) - 10, v1, v2, p2);
        n_checks++;
        if ({v2, p2} !== 2'b10) begin
            n_errors++;
            $display("FAIL facing_up_priority: got valid=%b is_pac=%b, want 1 0", v2, p2);
        end
    endtask

    task automatic test_random();
        bit ev[$];
        bit ep[$];
        bit v, want_v, want_p;
        int px, py;
        do_reset();
        for (int b = 0; b < 6; b++) begin
            pos_x = CW'($urandom_range(100, 1900));
            pos_y = CW'($urandom_range(100, 1900));
            for (int t = 0; t < int'($urandom_range(0, 7)); t++)
                tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            ev.delete();
            ep.delete();
            for (int c = 0; c < 42; c++) begin
                v  = (c < 40) && ($urandom_range(0, 4) != 0);
                px = int'(pos_x) + $signed($urandom_range(0, 80)) - 40;
                py = int'(pos_y) + $signed($urandom_range(0, 80)) - 40;
                pif.pix_valid = v;
                pif.pix_x = CW'(px);
                pif.pix_y = CW'(py);
                ev.push_back(v);
                ep.push_back(v && model_pac(px, py, int'(pos_x), int'(pos_y)));
                @(posedge clk);
                #1;
                if (c >= 1) begin
                    want_v = ev.pop_front();
                    want_p = ep.pop_front();
                    n_checks++;
                    if ({pif.is_pac_valid, pif.is_pac} !== {want_v, want_p}) begin
                        n_errors++;
                        $display("FAIL random_b%0d_c%0d: got valid=%b is_pac=%b, want %b %b (face=%0d lvl=%0d)",
                                 b, c, pif.is_pac_valid, pif.is_pac, want_v, want_p, m_face, model_level());
                    end
                end
            end
            pif.pix_valid = 0;
        end
        pos_x = 11'd500;
        pos_y = 11'd400;
    endtask

    task automatic test_reset_inflight();
        bit seen;
        bit v1, v2, p2;
        do_reset();
        for (int t = 0; t < FPS; t++) tick(0, 0, 0, 0);
        pif.pix_x = pos_x;
        pif.pix_y = pos_y;
        pif.pix_valid = 1;
        @(posedge clk);
        @(posedge clk);
        #1 pif.pix_valid = 0;
        #2 resetn = 0;
        #1;
        n_checks++;
        if ({pif.is_pac_valid, mouth_level} !== '0) begin
            n_errors++;
            $display("FAIL inflight_reset_now: got valid=%b lvl=%0d, want 0 0", pif.is_pac_valid, mouth_level);
        end
        @(posedge clk);
        #1 resetn = 1;
        m_ticks = 0;
        m_face  = 0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1 seen |= pif.is_pac_valid;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_errors++;
            $display("FAIL inflight_flushed: got a valid output, want none");
        end
        send_pixel(int'(pos_x) + 5, int'(pos_y), v1, v2, p2);
        n_checks++;
        if ({v1, v2, p2} !== 3'b011) begin
            n_errors++;
            $display("FAIL after_reset_latency: got v1=%b v2=%b is_pac=%b, want 0 1 1", v1, v2, p2);
        end
    endtask

`ifdef PAC_DEATH_ANIM_EN
    task automatic pulse(input bit d, input bit rv);
        die = d;
        revive = rv;
        @(posedge clk);
        #1 die = 0;
        revive = 0;
    endtask

    task automatic test_death();
        bit v1, v2, p2;
        do_reset();
        pulse(1, 1);
        for (int t = 0; t < 2 * FPS; t++) tick(0, 0, 0, 0);
        send_pixel(int'(pos_x), int'(pos_y) + 20, v1, v2, p2);
        n_checks++;
        if ({v2, p2} !== 2'b11) begin
            n_errors++;
            $display("FAIL revive_priority: got valid=%b is_pac=%b, want 1 1", v2, p2);
        end
        do_reset();
        pulse(1, 0);
        for (int t = 0; t < 2 * FPS; t++) tick(0, 0, 0, 0);
        send_pixel(int'(pos_x) + 15, int'(pos_y), v1, v2, p2);
        n_checks++;
        if ({v2, p2} !== 2'b11) begin
            n_errors++;
            $display("FAIL dying_inside: got valid=%b is_pac=%b, want 1 1", v2, p2);
        end
        send_pixel(int'(pos_x) + 16, int'(pos_y), v1, v2, p2);
        n_checks++;
        if ({v2, p2} !== 2'b10) begin
            n_errors++;
            $display("FAIL dying_shrunk: got valid=%b is_pac=%b, want 1 0", v2, p2);
        end
        for (int t = 0; t < 2 * FPS; t++) tick(0, 0, 0, 0);
        send_pixel(int'(pos_x), int'(pos_y), v1, v2, p2);
        n_checks++;
        if ({v2, p2} !== 2'b10) begin
            n_errors++;
            $display("FAIL gone_centre: got valid=%b is_pac=%b, want 1 0", v2, p2);
        end
        pulse(0, 1);
        m_ticks = 0;
        send_pixel(int'(pos_x), int'(pos_y), v1, v2, p2);
        n_checks++;
        if ({v2, p2, mouth_level} !== {2'b11, 3'd0}) begin
            n_errors++;
            $display("FAIL revived: got valid=%b is_pac=%b lvl=%0d, want 1 1 0", v2, p2, mouth_level);
        end
    endtask
`endif

    initial begin
        pif.pix_x = '0;
        pif.pix_y = '0;
        pif.pix_valid = 0;
        test_reset();
        test_body();
        test_mouth_seq();
        test_facing();
        test_random();
        test_reset_inflight();
`ifdef PAC_DEATH_ANIM_EN
        test_death();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pac_sprite_anim.md
PAC_SPRITE_ANIM -- requirements
Module: pac_sprite_anim

Interface
REQ-001 Parameter COORD_W, default 11, unsigned pixel/position coordinate width.
REQ-002 Parameter RADIUS, default 31, body radius in pixels.
REQ-003 Parameter MOUTH_STEPS, default 4, number of mouth-opening levels above closed.
REQ-004 Parameter FRAMES_PER_STEP, default 4, frame ticks per mouth-level change.
REQ-005 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- pos_x, pos_y  in  COORD_W  sprite centre.
- pix_x, pix_y  in  COORD_W  pixel under test.
- pix_valid  in  1  pixel qualifier.
- up, left, down, right  in  1  requested facing.
- die  in  1  start death animation (PAC_DEATH_ANIM_EN only).
- revive  in  1  return to alive (PAC_DEATH_ANIM_EN only).
- is_pac  out  1  pixel lies on sprite.
- is_pac_valid  out  1  qualifies is_pac.
- mouth_level  out  clog2(MOUTH_STEPS+1)  current opening level.

Function
REQ-006 Stage 1 SHALL register signed dx = pix_x - pos_x and dy = pix_y - pos_y, each COORD_W+1 bits, together with pix_valid.
REQ-007 Stage 2 SHALL register is_pac and is_pac_valid; latency from pix_valid to is_pac_valid is exactly 2 cycles, throughput 1 pixel/cycle, no stall.
REQ-008 is_pac SHALL be 0 whenever is_pac_valid is 0.
REQ-009 Body test: dx*dx + dy*dy < RADIUS*RADIUS, with products at 2*(COORD_W+1) bits and no overflow.
REQ-010 Facing register SHALL update only on frame_tick, with priority up > left > down > right; if none is asserted, the previous facing is held.
REQ-011 Along-axis a: right = dx, left = -dx, down = dy, up = -dy; p = |perpendicular component|.
REQ-012 A pixel is in the mouth when a > 0 and p*MOUTH_STEPS < a*mouth_level; mouth pixels SHALL give is_pac = 0.
REQ-013 mouth_level 0 means no mouth; the centre pixel (dx = dy = 0) is never in the mouth.
REQ-014 A frame counter SHALL count frame_ticks modulo FRAMES_PER_STEP; on wrap, mouth_level steps one level.
REQ-015 mouth_level SHALL ping-pong: it rises 0 to MOUTH_STEPS, then falls back to 0, reversing direction at both endpoints without dwelling twice on an endpoint.
REQ-016 Facing and mouth state changes SHALL affect only pixels entering stage 2 after the update; no pixel uses mixed state.

Reset
REQ-017 While resetn = 0: is_pac = 0, is_pac_valid = 0, mouth_level = 0, direction = rising, frame counter = 0, facing = right, pipeline valids = 0, state = ALIVE.
REQ-018 Reset assertion mid-frame SHALL clear in-flight pixels immediately; the first valid output appears 2 cycles after the first pix_valid following deassertion.

Configuration
REQ-019 Macro PAC_DEATH_ANIM_EN, when defined, SHALL add an FSM with states ALIVE, DYING and GONE:
- ALIVE to DYING on die; d is reset to 0 on entry.
- In DYING, d increments per FRAMES_PER_STEP frame ticks; the body threshold is (RADIUS*RADIUS) >> d; mouth animation is frozen.
- DYING to GONE when d reaches 4; in GONE, is_pac = 0.
- revive from any state goes to ALIVE with mouth_level = 0; revive has priority over a simultaneous die.
REQ-020 Without PAC_DEATH_ANIM_EN, the die and revive ports SHALL exist but be ignored, the FSM SHALL be absent, and the block behaves as permanently ALIVE.

Verification
REQ-021 Defaults, facing right, mouth_level 0, pixel (pos+10, pos) -> is_pac = 1, two cycles after pix_valid.
REQ-022 Same pixel with mouth_level 4 -> is_pac = 0; pixel (pos-10, pos) -> 1; pixel (pos+31, pos) -> 0 (961 is not < 961).
REQ-023 36 consecutive frame_ticks -> mouth_level sequence 0,1,2,3,4,3,2,1,0, each level held for 4 ticks.
REQ-024 up and right asserted together at a frame_tick, mouth_level 4, pixel (pos, pos-10) -> is_pac = 0 (facing up).
REQ-025 resetn pulsed low while 2 pixels are in flight -> no is_pac_valid for those pixels, and mouth_level reads 0.
REQ-026 With PAC_DEATH_ANIM_EN: die, then 16 frame_ticks -> state GONE and is_pac = 0 at pixel (pos, pos); revive -> is_pac = 1 again.
